// File: rtl/uart_stream_transceiver.sv
// Full-duplex UART with a FIFO on each side and valid/ready byte streams.
// Width, parity, stop bits and FIFO depths are parameters; RX flags framing, parity and overrun.
//
// state    | meaning
// S_IDLE   | line idle (TX: waiting for FIFO data; RX: waiting for a 1->0 edge)
// S_START  | start bit (RX: mid-bit check rejects glitches)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (unused when PARITY=0)
// S_STOP   | stop bit(s); RX leaves at the mid-point of the first one
module uart_stream_transceiver #(
  parameter int BAUD_DIVIDER  = 434,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int TX_FIFO_DEPTH = 16,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 tx,
  input  logic                 rx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 tx_busy,
  output logic                 rx_parity_error,
  output logic                 rx_framing_error,
  output logic                 rx_overrun
);

  localparam int TX_AW  = $clog2(TX_FIFO_DEPTH);
  localparam int RX_AW  = $clog2(RX_FIFO_DEPTH);
  localparam int BAUD_W = $clog2(BAUD_DIVIDER);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIVIDER - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_DIVIDER / 2 - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic PAR_ODD = (PARITY == 2);
  localparam bit   PAR_EN  = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [TX_FIFO_DEPTH];
  logic [TX_AW:0]       tx_wr_ptr, tx_rd_ptr;
  logic                 tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                    (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
  // a pop frees the slot the same cycle, so a full FIFO can still accept
  assign tx_ready = !reset && (!tx_full || tx_pop);
  assign tx_push  = tx_valid && tx_ready;
  assign tx_head  = tx_mem[tx_rd_ptr[TX_AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= tx_data;
  end

  // ---------------- TX FSM ----------------
  state_t               tx_state, tx_state_n;
  logic [BAUD_W-1:0]    tx_baud, tx_baud_n;
  logic [BIT_W-1:0]     tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_par, tx_par_n, tx_line, tx_line_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_baud  <= tx_baud_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      tx_line  <= tx_line_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_baud_n  = tx_baud;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_line_n  = tx_line;
    tx_pop     = 1'b0;
    if (tx_state == S_IDLE) begin
      tx_pop = !tx_empty;
    end else if (tx_baud != '0) begin
      tx_baud_n = tx_baud - 1'b1;
    end else begin
      tx_baud_n = BAUD_LAST;
      case (tx_state)
        S_START: begin
          tx_state_n = S_DATA;
          tx_bit_n   = '0;
          tx_line_n  = tx_shift[0];
        end
        S_DATA: begin
          if (tx_bit == DATA_LAST) begin
            tx_bit_n = '0;
            if (PAR_EN) begin
              tx_state_n = S_PARITY;
              tx_line_n  = tx_par;
            end else begin
              tx_state_n = S_STOP;
              tx_line_n  = 1'b1;
            end
          end else begin
            tx_bit_n   = tx_bit + 1'b1;
            tx_shift_n = tx_shift >> 1;
            tx_line_n  = tx_shift[1];
          end
        end
        S_PARITY: begin
          tx_state_n = S_STOP;
          tx_bit_n   = '0;
          tx_line_n  = 1'b1;
        end
        S_STOP: begin
          if (tx_bit != STOP_LAST) begin
            tx_bit_n = tx_bit + 1'b1;
          end else if (!tx_empty) begin
            tx_pop = 1'b1;
          end else begin
            tx_state_n = S_IDLE;
            tx_line_n  = 1'b1;
          end
        end
        default: tx_state_n = S_IDLE;
      endcase
    end
    // loading from IDLE or straight out of STOP keeps characters back-to-back
    if (tx_pop) begin
      tx_state_n = S_START;
      tx_baud_n  = BAUD_LAST;
      tx_shift_n = tx_head;
      tx_par_n   = (^tx_head) ^ PAR_ODD;
      tx_line_n  = 1'b0;
    end
  end

  assign tx      = tx_line;
  assign tx_busy = !reset && (!tx_empty || tx_state != S_IDLE);

  // ---------------- RX synchroniser ----------------
  logic [1:0] rx_sync;
  logic       rx_s, rx_prev;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_prev <= rx_s;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem [RX_FIFO_DEPTH];
  logic [RX_AW:0]       rx_wr_ptr, rx_rd_ptr;
  logic                 rx_empty, rx_full, rx_push, rx_pop;

  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                    (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
  assign rx_valid = !reset && !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_data  = rx_mem[rx_rd_ptr[RX_AW-1:0]];

  // ---------------- RX FSM ----------------
  state_t               rx_state, rx_state_n;
  logic [BAUD_W-1:0]    rx_baud, rx_baud_n;
  logic [BIT_W-1:0]     rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_par, rx_par_n;
  logic                 perr_n, ferr_n, ovr_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state         <= S_IDLE;
      rx_baud          <= '0;
      rx_bit           <= '0;
      rx_shift         <= '0;
      rx_par           <= 1'b0;
      rx_wr_ptr        <= '0;
      rx_rd_ptr        <= '0;
      rx_parity_error  <= 1'b0;
      rx_framing_error <= 1'b0;
      rx_overrun       <= 1'b0;
    end else begin
      rx_state         <= rx_state_n;
      rx_baud          <= rx_baud_n;
      rx_bit           <= rx_bit_n;
      rx_shift         <= rx_shift_n;
      rx_par           <= rx_par_n;
      rx_parity_error  <= perr_n;
      rx_framing_error <= ferr_n;
      rx_overrun       <= ovr_n;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_shift;
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_baud_n  = rx_baud;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_par_n   = rx_par;
    perr_n     = 1'b0;
    ferr_n     = 1'b0;
    ovr_n      = 1'b0;
    rx_push    = 1'b0;
    if (rx_state == S_IDLE) begin
      if (rx_prev && !rx_s) begin
        rx_state_n = S_START;
        rx_baud_n  = BAUD_HALF;
      end
    end else if (rx_baud != '0) begin
      rx_baud_n = rx_baud - 1'b1;
    end else begin
      rx_baud_n = BAUD_LAST;
      case (rx_state)
        S_START: begin
          rx_bit_n   = '0;
          rx_state_n = rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          rx_shift_n = {rx_s, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == DATA_LAST) rx_state_n = PAR_EN ? S_PARITY : S_STOP;
          else                     rx_bit_n   = rx_bit + 1'b1;
        end
        S_PARITY: begin
          rx_par_n   = rx_s;
          rx_state_n = S_STOP;
        end
        S_STOP: begin
          // framing outranks parity; an accepted character needs room or a pop
          rx_state_n = S_IDLE;
          if (!rx_s)                                          ferr_n  = 1'b1;
          else if (PAR_EN && ((^rx_shift) ^ PAR_ODD ^ rx_par)) perr_n  = 1'b1;
          else if (rx_full && !rx_pop)                        ovr_n   = 1'b1;
          else                                                rx_push = 1'b1;
        end
        default: rx_state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stream_transceiver.sv
// Randomized self-checking bench: an 8N1 instance (TX frames, loopback burst, overrun, glitch, reset)
// and a 7E2 instance (parity/framing), both checked against a frame-level reference model.
module tb_uart_stream_transceiver;
  localparam int BD = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset0, reset1;
  logic       tx0, rx0, rx0_drv, loop0;
  logic [7:0] tx_data0, rx_data0;
  logic       tx_valid0, tx_ready0, rx_valid0, rx_ready0, tx_busy0, perr0, ferr0, orun0;
  logic       tx1, rx1_drv;
  logic [6:0] tx_data1, rx_data1;
  logic       tx_valid1, tx_ready1, rx_valid1, rx_ready1, tx_busy1, perr1, ferr1, orun1;

  assign rx0 = loop0 ? tx0 : rx0_drv;

  uart_stream_transceiver #(
    .BAUD_DIVIDER(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .TX_FIFO_DEPTH(16), .RX_FIFO_DEPTH(16)
  ) u_dut0 (
    .clock(clock), .reset(reset0), .tx(tx0), .rx(rx0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .tx_busy(tx_busy0), .rx_parity_error(perr0), .rx_framing_error(ferr0), .rx_overrun(orun0)
  );

  uart_stream_transceiver #(
    .BAUD_DIVIDER(BD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2),
    .TX_FIFO_DEPTH(16), .RX_FIFO_DEPTH(16)
  ) u_dut1 (
    .clock(clock), .reset(reset1), .tx(tx1), .rx(rx1_drv),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .tx_busy(tx_busy1), .rx_parity_error(perr1), .rx_framing_error(ferr1), .rx_overrun(orun1)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int pcnt0 = 0, fcnt0 = 0, ocnt0 = 0, pcnt1 = 0, fcnt1 = 0, ocnt1 = 0;
  int last_fall = 0;
  logic busy_q = 1'b0;
  bit   ready_low_seen;
  logic [7:0] rxq0[$];
  logic [6:0] rxq1[$];
  logic [6:0] expq1[$];
  int exp_p1 = 0, exp_f1 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rx_valid0 && rx_ready0) rxq0.push_back(rx_data0);
    if (rx_valid1 && rx_ready1) rxq1.push_back(rx_data1);
    if (perr0) pcnt0++;
    if (ferr0) fcnt0++;
    if (orun0) ocnt0++;
    if (perr1) pcnt1++;
    if (ferr1) fcnt1++;
    if (orun1) ocnt1++;
    if (busy_q && !tx_busy0) last_fall = cyc;
    busy_q = tx_busy0;
  end

  // Serial frame as seen on the line: start, data LSB first, optional parity, stop bits.
  function automatic void make_frame(input logic [8:0] d, input int nb, input int par,
                                     input int stops, input bit bad_par, input bit bad_stop,
                                     output logic [15:0] f, output int len);
    logic p;
    f    = '0;
    f[0] = 1'b0;
    len  = 1;
    p    = 1'b0;
    for (int i = 0; i < nb; i++) begin
      f[len] = d[i];
      p      = p ^ d[i];
      len++;
    end
    if (par != 0) begin
      if (par == 2) p = ~p;
      if (bad_par)  p = ~p;
      f[len] = p;
      len++;
    end
    for (int s = 0; s < stops; s++) begin
      f[len] = !(bad_stop && s == 0);
      len++;
    end
  endfunction

  task automatic drive(input int sel, input logic [15:0] f, input int len);
    for (int i = 0; i < len; i++) begin
      if (sel == 0) rx0_drv = f[i];
      else          rx1_drv = f[i];
      repeat (BD) @(negedge clock);
    end
    if (sel == 0) rx0_drv = 1'b1;
    else          rx1_drv = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic push0(input logic [7:0] d);
    int n;
    n = 0;
    tx_data0  = d;
    tx_valid0 = 1'b1;
    while (!tx_ready0 && n < 4000) begin
      ready_low_seen = 1'b1;
      @(negedge clock);
      n++;
    end
    if (n >= 4000) chk("push_wait", n, 0);
    @(posedge clock);
    @(negedge clock);
    tx_valid0 = 1'b0;
  endtask

  task automatic tx_frame_check(input logic [7:0] d);
    logic [15:0] f;
    int len, rel;
    make_frame({1'b0, d}, 8, 0, 1, 1'b0, 1'b0, f, len);
    chk("tx_lat1", tx0, 1);
    @(negedge clock);
    rel = 2;
    chk("tx_lat2", tx0, 0);
    for (int i = 0; i < len; i++) begin
      while (rel < 2 + BD * i + BD / 2) begin
        @(negedge clock);
        rel++;
      end
      chk($sformatf("tx_bit%0d_%02h", i, d), tx0, f[i]);
    end
    while (rel < 1 + BD * len) begin
      @(negedge clock);
      rel++;
    end
    chk("tx_busy_last", tx_busy0, 1);
    @(negedge clock);
    chk("tx_busy_fall", tx_busy0, 0);
  endtask

  // 7E2 receive model: framing outranks parity; good characters land in the FIFO.
  task automatic rx1_frame(input logic [6:0] d, input bit bad_par, input bit bad_stop);
    logic [15:0] f;
    int len;
    make_frame({2'b00, d}, 7, 1, 2, bad_par, bad_stop, f, len);
    drive(1, f, len);
    if (bad_stop)     exp_f1++;
    else if (bad_par) exp_p1++;
    else              expq1.push_back(d);
    repeat (4) @(negedge clock);
    chk("rx1_count", rxq1.size(), expq1.size());
    chk("rx1_perr", pcnt1, exp_p1);
    chk("rx1_ferr", fcnt1, exp_f1);
    if (rxq1.size() == expq1.size() && rxq1.size() > 0)
      chk("rx1_data", rxq1[rxq1.size()-1], expq1[expq1.size()-1]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d, sent[$], ov[$];
    logic [15:0] f;
    int len, n, t0, p_s, f_s, o_s;

    reset0 = 1'b1; reset1 = 1'b1;
    rx0_drv = 1'b1; rx1_drv = 1'b1; loop0 = 1'b0;
    tx_data0 = '0; tx_valid0 = 1'b0; rx_ready0 = 1'b1;
    tx_data1 = '0; tx_valid1 = 1'b0; rx_ready1 = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_tx", tx0, 1);
    chk("rst_tx_ready", tx_ready0, 0);
    chk("rst_rx_valid", rx_valid0, 0);
    chk("rst_tx_busy", tx_busy0, 0);
    chk("rst_errs", {perr0, ferr0, orun0}, 0);
    chk("rst_tx_ready1", tx_ready1, 0);
    reset0 = 1'b0; reset1 = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", tx_ready0, 1);

    // single characters, idle line between them
    push0(8'h41);
    tx_frame_check(8'h41);
    repeat (3) begin
      d = 8'($urandom);
      repeat ($urandom_range(1, 5)) @(negedge clock);
      push0(d);
      tx_frame_check(d);
    end

    // loopback burst: FIFO fills, line must stay back-to-back
    loop0 = 1'b1;
    rxq0.delete();
    p_s = pcnt0; f_s = fcnt0; o_s = ocnt0;
    ready_low_seen = 1'b0;
    sent = '{8'h00, 8'h55, 8'hAA, 8'hFF};
    repeat (17) sent.push_back(8'($urandom));
    push0(sent[0]);
    t0 = cyc;
    for (int i = 1; i < sent.size(); i++) push0(sent[i]);
    chk("burst_ready_low", ready_low_seen, 1);
    n = 0;
    while (rxq0.size() < sent.size() && n < 3000) begin
      @(negedge clock);
      n++;
    end
    repeat (5) @(negedge clock);
    chk("burst_count", rxq0.size(), sent.size());
    for (int i = 0; i < sent.size() && i < rxq0.size(); i++)
      chk($sformatf("burst_byte%0d", i), rxq0[i], sent[i]);
    chk("burst_end_time", last_fall - t0, 1 + sent.size() * 10 * BD);
    chk("burst_errs", (pcnt0 - p_s) + (fcnt0 - f_s) + (ocnt0 - o_s), 0);
    loop0 = 1'b0;

    // overrun: 17 characters into a 16-deep FIFO with no consumer
    rx_ready0 = 1'b0;
    rxq0.delete();
    p_s = pcnt0; f_s = fcnt0; o_s = ocnt0;
    repeat (17) ov.push_back(8'($urandom));
    foreach (ov[i]) begin
      make_frame({1'b0, ov[i]}, 8, 0, 1, 1'b0, 1'b0, f, len);
      drive(0, f, len);
    end
    repeat (20) @(negedge clock);
    chk("ovr_pulse", ocnt0 - o_s, 1);
    chk("ovr_other_errs", (pcnt0 - p_s) + (fcnt0 - f_s), 0);
    chk("ovr_valid", rx_valid0, 1);
    chk("ovr_head", rx_data0, ov[0]);
    rx_ready0 = 1'b1;
    n = 0;
    while (rxq0.size() < 16 && n < 200) begin
      @(negedge clock);
      n++;
    end
    repeat (10) @(negedge clock);
    chk("ovr_drain_count", rxq0.size(), 16);
    for (int i = 0; i < 16 && i < rxq0.size(); i++)
      chk($sformatf("ovr_byte%0d", i), rxq0[i], ov[i]);

    // glitch on rx: 2-cycle low pulse
    rxq0.delete();
    p_s = pcnt0; f_s = fcnt0; o_s = ocnt0;
    rx0_drv = 1'b0;
    repeat (2) @(negedge clock);
    rx0_drv = 1'b1;
    repeat (40) @(negedge clock);
    chk("glitch_no_char", rxq0.size(), 0);
    chk("glitch_no_err", (pcnt0 - p_s) + (fcnt0 - f_s) + (ocnt0 - o_s), 0);

    // reset in the middle of data bit 3, loopback active so RX is mid-character too
    loop0 = 1'b1;
    d = 8'($urandom);
    push0(d);
    repeat (37) @(negedge clock);
    chk("pre_reset_bit3", tx0, d[3]);
    reset0 = 1'b1;
    #1;
    chk("reset_ready_low", tx_ready0, 0);
    @(negedge clock);
    chk("reset_tx_high", tx0, 1);
    chk("reset_busy", tx_busy0, 0);
    chk("reset_rx_valid", rx_valid0, 0);
    reset0 = 1'b0;
    p_s = pcnt0; f_s = fcnt0; o_s = ocnt0;
    @(negedge clock);
    chk("reset_ready_back", tx_ready0, 1);
    repeat (30) @(negedge clock);
    chk("reset_no_partial", rxq0.size(), 0);
    d = 8'($urandom);
    push0(d);
    tx_frame_check(d);
    repeat (10) @(negedge clock);
    chk("reset_new_count", rxq0.size(), 1);
    if (rxq0.size() > 0) chk("reset_new_byte", rxq0[0], d);
    chk("reset_new_errs", (pcnt0 - p_s) + (fcnt0 - f_s) + (ocnt0 - o_s), 0);
    loop0 = 1'b0;

    // 7E2 instance: parity and framing
    rx1_frame(7'h35, 1'b0, 1'b0);
    rx1_frame(7'h35, 1'b1, 1'b0);
    rx1_frame(7'h3C, 1'b0, 1'b1);
    rx1_frame(7'h2A, 1'b1, 1'b1);
    repeat (20) @(negedge clock);
    rx1_frame(7'h3D, 1'b0, 1'b0);
    repeat (6) begin
      n = $urandom_range(0, 3);
      rx1_frame(7'($urandom), n == 1 || n == 3, n >= 2);
      repeat ($urandom_range(0, 12)) @(negedge clock);
    end
    chk("rx1_no_overrun", ocnt1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
